// File: rtl/framebuffer_multiscan.sv
// framebuffer_multiscan: double-buffered N-section HUB75 framebuffer with frame-synchronised swap.
// Optional FB_AUTOCLEAR_EN zero-fills the new back buffer after every swap.
module framebuffer_multiscan #(
  parameter int N_ROWS_MAX   = 64,
  parameter int N_COLS_MAX   = 256,
  parameter int N_SECTIONS   = 2,
  parameter int BITDEPTH_MAX = 8,
  parameter int DATA_WIDTH   = 32,
  parameter int ROW_W        = $clog2(N_ROWS_MAX),
  parameter int COL_W        = $clog2(N_COLS_MAX),
  parameter int LROW_W       = $clog2(N_ROWS_MAX / N_SECTIONS)
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic [4:0]                      ctrl_scan_log2,
  input  logic [3:0]                      ctrl_bitdepth,
  input  logic                            w_en,
  output logic                            w_ready,
  input  logic [ROW_W-1:0]                w_row,
  input  logic [COL_W-1:0]                w_col,
  input  logic [DATA_WIDTH/8-1:0]         w_strb,
  input  logic [DATA_WIDTH-1:0]           w_din,
  output logic                            w_err,
  input  logic                            swap_req,
  input  logic                            frame_end,
  output logic                            swap_pending,
  output logic                            swap_done,
  output logic                            front_buf,
  input  logic                            r_en,
  input  logic [LROW_W-1:0]               r_row,
  input  logic [COL_W-1:0]                r_col,
  input  logic [$clog2(BITDEPTH_MAX)-1:0] r_bit,
  output logic                            r_valid,
  output logic [3*N_SECTIONS-1:0]         r_dout
);
  localparam int BIT_W = $clog2(BITDEPTH_MAX);
  localparam int IW    = $clog2(DATA_WIDTH);
  localparam int AW    = 1 + LROW_W + COL_W;
  localparam int DEPTH = 1 << AW;
`ifdef FB_AUTOCLEAR_EN
  typedef enum logic [1:0] {IDLE, PENDING, CLEAR} state_t;
  localparam state_t S_SWAP = CLEAR;
`else
  typedef enum logic [1:0] {IDLE, PENDING} state_t;
  localparam state_t S_SWAP = IDLE;
`endif
  state_t                  r_state;
  logic [ROW_W-1:0]        w_sec, w_mask;
  logic [LROW_W-1:0]       w_lrow;
  logic                    w_oor, w_fire, w_clr, w_bit_ok;
  logic [AW-1:0]           w_waddr;
  logic [IW-1:0]           w_ri, w_gi, w_bi;
  logic [3*N_SECTIONS-1:0] w_rgb;
  logic                    r_v1;
  logic [BIT_W-1:0]        r_bit1;
  assign w_sec  = w_row >> ctrl_scan_log2;
  assign w_mask = ~({ROW_W{1'b1}} << ctrl_scan_log2);
  assign w_lrow = LROW_W'(w_row & w_mask);
  assign w_oor  = 32'(w_sec) >= N_SECTIONS;
  assign w_fire = w_en && w_ready;
  assign swap_pending = r_state == PENDING;
`ifdef FB_AUTOCLEAR_EN
  logic [AW-2:0] r_clr;
  logic          r_latch;
  assign w_clr   = r_state == CLEAR;
  assign w_ready = !w_clr;
  assign w_waddr = w_clr ? {~front_buf, r_clr} : {~front_buf, w_lrow, w_col};
`else
  assign w_clr   = 1'b0;
  assign w_ready = 1'b1;
  assign w_waddr = {~front_buf, w_lrow, w_col};
`endif
  // Bitplane indices into the {R,G,B} word, shared by every section.
  assign w_bi     = IW'(r_bit1);
  assign w_gi     = IW'(ctrl_bitdepth) + IW'(r_bit1);
  assign w_ri     = w_gi + IW'(ctrl_bitdepth);
  assign w_bit_ok = 32'(r_bit1) < 32'(ctrl_bitdepth);
  for (genvar s = 0; s < N_SECTIONS; s++) begin : g_bank
    logic [DATA_WIDTH-1:0] r_mem [DEPTH];
    logic [DATA_WIDTH-1:0] r_word;
    logic                  w_we;
    assign w_we = w_clr || (w_fire && !w_oor && w_sec == ROW_W'(s));
    always_ff @(posedge clk) begin
      for (int b = 0; b < DATA_WIDTH / 8; b++)
        if (w_we && (w_clr || w_strb[b])) r_mem[w_waddr][b*8 +: 8] <= w_clr ? 8'd0 : w_din[b*8 +: 8];
      if (r_en) r_word <= r_mem[{front_buf, r_row, r_col}];
    end
    assign w_rgb[3*(N_SECTIONS-1-s) +: 3] = {r_word[w_ri], r_word[w_gi], r_word[w_bi]};
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_v1    <= 1'b0;
      r_bit1  <= '0;
      r_valid <= 1'b0;
      r_dout  <= '0;
    end else begin
      r_v1    <= r_en;
      r_valid <= r_v1;
      if (r_en) r_bit1 <= r_bit;
      if (r_v1) r_dout <= w_bit_ok ? w_rgb : '0;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= IDLE;
      front_buf <= 1'b0;
      swap_done <= 1'b0;
      w_err     <= 1'b0;
`ifdef FB_AUTOCLEAR_EN
      r_clr     <= '0;
      r_latch   <= 1'b0;
`endif
    end else begin
      swap_done <= 1'b0;
      w_err     <= w_fire && w_oor;
      case (r_state)
        IDLE: begin
          if (swap_req && frame_end) begin
            front_buf <= ~front_buf;
            swap_done <= 1'b1;
            r_state   <= S_SWAP;
          end else if (swap_req) r_state <= PENDING;
        end
        PENDING: begin
          if (frame_end) begin
            front_buf <= ~front_buf;
            swap_done <= 1'b1;
            r_state   <= S_SWAP;
          end
        end
`ifdef FB_AUTOCLEAR_EN
        CLEAR: begin
          r_clr   <= r_clr + 1'b1;
          r_latch <= r_latch || swap_req;
          if (&r_clr) begin
            r_state <= (r_latch || swap_req) ? PENDING : IDLE;
            r_latch <= 1'b0;
          end
        end
`endif
        default: r_state <= IDLE;
      endcase
    end
  end
endmodule
